select_scan_n: RTL and testbench
================================

// Module: select_scan_n
// PURPOSE
//  Parametrised, tick-paced channel scanner/serialiser; successor of the fixed 16:1 selector.
//  - Snapshots NUM_CH channels of CH_W bits, then emits them one slot per tick step.
//  - Slot order: START marker, enabled channels in index order, optional PARITY slot.
//  - Sits between the counter/status logic and the UART/bit-line driver.
// PARAMETERS
//  NUM_CH     16  number of input channels (2..64)
//  CH_W       1   bits per channel (1..8)
//  EDGE_MODE  1   0: step on time_tick rising edge only; 1: step on both edges
//  SLOT_W     $clog2(NUM_CH+2)  slot index width (derived, not overridable)
// PORTS
//  clk_in     in   1              system clock
//  reset      in   1              asynchronous, active-low reset
//  in         in   NUM_CH*CH_W    channel data; channel k = in[k*CH_W +: CH_W], k=0..NUM_CH-1
//  time_tick  in   1              slow pacing level/pulse, asynchronous to clk_in
//  en         in   1              run request
//  cont       in   1              1: continuous frames; 0: single frame per en rise
//  ch_mask    in   NUM_CH         1 = channel emitted; 0 = channel skipped
//  parity_en  in   1              1 = append PARITY slot
//  start      out  1              high during START slot
//  out        out  CH_W           slot data
//  out_valid  out  1              high during DATA and PARITY slots
//  slot       out  SLOT_W         0 = START, k+1 = channel k, NUM_CH+1 = PARITY
//  busy       out  1              high in every state except IDLE
//  frame_done out  1              one-cycle pulse when the last slot of a frame ends
// BEHAVIOUR
//  - Reset values: state IDLE; sync flops 0; all outputs 0; snapshot 0; parity 0.
//  - Tick sync: time_tick -> q1 -> q2.
//    - step = q1 & ~q2 when EDGE_MODE=0; step = q1 ^ q2 when EDGE_MODE=1.
//    - State and outputs update on the 2nd clk_in edge after a time_tick transition.
//  - All outputs are registered. No X is ever driven: out = 0 in IDLE and START.
//  - Every state transition other than IDLE->START is qualified by step.
//  - FSM:
//    - IDLE: on en=1 with (cont=1 or en rising edge), go to START at the next clock (no step needed).
//    - START: start=1, slot=0. Snapshot in and ch_mask at entry; the frame uses only the snapshot.
//      On step: go to DATA at the lowest enabled channel. If the mask is all zero, go to PARITY
//      (parity_en=1) or END.
//    - DATA: out = snapshot channel, slot = ch+1. On step: go to the next higher enabled channel.
//      After the highest enabled channel, go to PARITY (parity_en=1) or END.
//    - PARITY: out = XOR of all CH_W-bit words emitted in this frame (0 for an empty mask);
//      slot = NUM_CH+1. On step: go to END.
//    - END: internal, one clk_in cycle, frame_done=1, out_valid=0.
//      Go to START if en=1 and cont=1; otherwise go to IDLE.
//  - parity_en is sampled at START entry together with the snapshot.
//  - en dropped mid-frame: the frame completes normally, then IDLE. No truncated frames.
//  - en re-asserted during END with cont=0: needs a fresh en rising edge seen in IDLE.
//  - A step arriving in the same cycle as IDLE->START is ignored; START always lasts >=1 step period.
//  - Async reset mid-frame: immediate return to IDLE, all outputs 0; the frame is abandoned.
//  - Channel pointer wraps only via END/START; it never exceeds NUM_CH-1.
//  - Parity accumulator clears at START entry and is CH_W bits wide.
// STRUCTURE
//  - Package scan_pkg: FSM state encoding (IDLE, START, DATA, PARITY, END) and slot constants
//    SLOT_START=0, SLOT_PARITY=NUM_CH+1.
//  - Sub-module next_en_ch: combinational "lowest set bit of mask above index i" with found flag;
//    used for both first-channel and next-channel lookup.
//  - Top level holds the sync/edge detector, FSM, snapshot registers and parity accumulator.
// TESTING
//  1. NUM_CH=16, CH_W=1, mask=FFFF, parity_en=0, cont=0, in=A5C3, pulse en:
//     -> start, then 16 DATA slots in order ch0..ch15, then frame_done, then IDLE.
//  2. mask=0x0011, parity_en=1, in ch0=1, ch4=1:
//     -> slots 0,1,5,17 with out = -,1,1,0; frame_done once.
//  3. mask=0, parity_en=1 -> START, PARITY out=0, END.
//     Repeat with parity_en=0 -> START, then END directly.
//  4. cont=1; drop en during slot 9 -> frame finishes through slot 16/END; then busy=0.
//     Change in mid-frame -> no effect until the next START.
//  5. EDGE_MODE=0 vs 1 with a 50% duty time_tick -> the slot rate differs by exactly 2x;
//     each update lands 2 clk_in edges after the tick transition.
//  6. Assert reset during DATA slot 7 -> all outputs 0 asynchronously.
//     After release with en=1 and cont=1 -> a new frame starts at slot 0.
//     Run NUM_CH=5, CH_W=4 -> same checks, with parity = nibble XOR.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared FSM encoding and slot numbering for the channel scanner.
package scan_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_START  = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA   = 3'd2;
    localparam logic [ST_W-1:0] ST_PARITY = 3'd3;
    localparam logic [ST_W-1:0] ST_END    = 3'd4;

    localparam int unsigned SLOT_START = 0;

    // PARITY slot number follows the last channel slot
    function automatic int unsigned slot_parity(input int unsigned num_ch);
        return num_ch + 1;
    endfunction

endpackage

// File: rtl/next_en_ch.sv
// Lowest set mask bit strictly above cur, or the lowest set bit overall when from_first is high.
module next_en_ch #(
    parameter int unsigned NUM_CH = 16,
    localparam int unsigned IDX_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [IDX_W-1:0]  cur,
    input  logic              from_first,
    output logic [IDX_W-1:0]  idx_c,
    output logic              found_c
);

    // Scan downward so the last hit written is the lowest qualifying index
    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (mask[k] && (from_first || (IDX_W'(k) > cur))) begin
                idx_c   = IDX_W'(k);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/select_scan_n.sv
// Tick-paced channel scanner: snapshots NUM_CH channels and emits START, enabled channels, optional PARITY.
module select_scan_n
    import scan_pkg::*;
#(
    parameter int unsigned NUM_CH    = 16,
    parameter int unsigned CH_W      = 1,
    parameter int unsigned EDGE_MODE = 1,
    localparam int unsigned SLOT_W   = $clog2(NUM_CH + 2)
) (
    input  logic                   clk_in,
    input  logic                   reset,
    input  logic [NUM_CH*CH_W-1:0] in,
    input  logic                   time_tick,
    input  logic                   en,
    input  logic                   cont,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic                   parity_en,
    output logic                   start,
    output logic [CH_W-1:0]        out,
    output logic                   out_valid,
    output logic [SLOT_W-1:0]      slot,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int unsigned IDX_W  = $clog2(NUM_CH);
    localparam int unsigned DATA_W = NUM_CH * CH_W;

    logic              tick_q1, tick_q2, en_q;
    logic              step_c;
    logic [ST_W-1:0]   state_q, state_d;
    logic [IDX_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0] snap_in_q, snap_in_d;
    logic [NUM_CH-1:0] snap_mask_q, snap_mask_d;
    logic              par_en_q, par_en_d;
    logic              load_c;
    logic [IDX_W-1:0]  nxt_idx_c;
    logic              nxt_found_c;

    logic              start_d, out_valid_d, busy_d, frame_done_d;
    logic [CH_W-1:0]   out_d;
    logic [SLOT_W-1:0] slot_d;

    function automatic logic [CH_W-1:0] word_at(input logic [DATA_W-1:0] data,
                                                 input logic [IDX_W-1:0]  idx);
        return data[32'(idx) * CH_W +: CH_W];
    endfunction

    assign step_c = (EDGE_MODE == 0) ? (tick_q1 & ~tick_q2) : (tick_q1 ^ tick_q2);

    next_en_ch #(.NUM_CH(NUM_CH)) u_next_en_ch (
        .mask       (snap_mask_q),
        .cur        (ch_q),
        .from_first (state_q == ST_START),
        .idx_c      (nxt_idx_c),
        .found_c    (nxt_found_c)
    );

    // Next state, frame bookkeeping and next registered outputs
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        acc_d       = acc_q;
        snap_in_d   = snap_in_q;
        snap_mask_d = snap_mask_q;
        par_en_d    = par_en_q;
        load_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && (cont || !en_q)) begin
                    state_d = ST_START;
                    load_c  = 1'b1;
                end
            end
            ST_START, ST_DATA: begin
                if (step_c) begin
                    if (nxt_found_c) begin
                        state_d = ST_DATA;
                        ch_d    = nxt_idx_c;
                        acc_d   = acc_q ^ word_at(snap_in_q, nxt_idx_c);
                    end else if (par_en_q) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_END;
                    end
                end
            end
            ST_PARITY: begin
                if (step_c) state_d = ST_END;
            end
            ST_END: begin
                if (en && cont) begin
                    state_d = ST_START;
                    load_c  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_c) begin
            snap_in_d   = in;
            snap_mask_d = ch_mask;
            par_en_d    = parity_en;
            acc_d       = '0;
            ch_d        = '0;
        end

        start_d      = (state_d == ST_START);
        busy_d       = (state_d != ST_IDLE);
        frame_done_d = (state_d == ST_END);
        out_valid_d  = (state_d == ST_DATA) || (state_d == ST_PARITY);
        slot_d       = SLOT_W'(SLOT_START);
        out_d        = '0;
        if (state_d == ST_DATA) begin
            slot_d = SLOT_W'(ch_d) + SLOT_W'(1);
            out_d  = word_at(snap_in_q, ch_d);
        end else if (state_d == ST_PARITY) begin
            slot_d = SLOT_W'(slot_parity(NUM_CH));
            out_d  = acc_d;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick_q1     <= 1'b0;
            tick_q2     <= 1'b0;
            en_q        <= 1'b0;
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            acc_q       <= '0;
            snap_in_q   <= '0;
            snap_mask_q <= '0;
            par_en_q    <= 1'b0;
            start       <= 1'b0;
            out         <= '0;
            out_valid   <= 1'b0;
            slot        <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            tick_q1     <= time_tick;
            tick_q2     <= tick_q1;
            en_q        <= en;
            state_q     <= state_d;
            ch_q        <= ch_d;
            acc_q       <= acc_d;
            snap_in_q   <= snap_in_d;
            snap_mask_q <= snap_mask_d;
            par_en_q    <= par_en_d;
            start       <= start_d;
            out         <= out_d;
            out_valid   <= out_valid_d;
            slot        <= slot_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_select_scan_n.sv
// Bench for select_scan_n: three configurations checked slot by slot against a frame-level model.
module tb_select_scan_n;

    localparam int ACT_NONE  = 0;
    localparam int ACT_DROP  = 1;
    localparam int ACT_RESET = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] in_a = '0, in_b = '0;
    logic [19:0] in_c = '0;
    logic [15:0] mask_a = '0, mask_b = '0;
    logic [4:0]  mask_c = '0;
    logic [2:0]  en_v = '0, cont_v = '0, pe_v = '0;

    logic       start_a, out_a, valid_a, busy_a, done_a;
    logic [4:0] slot_a;
    logic       start_b, out_b, valid_b, busy_b, done_b;
    logic [4:0] slot_b;
    logic       start_c, valid_c, busy_c, done_c;
    logic [3:0] out_c;
    logic [2:0] slot_c;

    logic [12:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    select_scan_n #(.NUM_CH(16), .CH_W(1), .EDGE_MODE(1)) dut_a (
        .clk_in(clk), .reset(rst_n), .in(in_a), .time_tick(tick), .en(en_v[0]),
        .cont(cont_v[0]), .ch_mask(mask_a), .parity_en(pe_v[0]), .start(start_a),
        .out(out_a), .out_valid(valid_a), .slot(slot_a), .busy(busy_a), .frame_done(done_a));

    select_scan_n #(.NUM_CH(16), .CH_W(1), .EDGE_MODE(0)) dut_b (
        .clk_in(clk), .reset(rst_n), .in(in_b), .time_tick(tick), .en(en_v[1]),
        .cont(cont_v[1]), .ch_mask(mask_b), .parity_en(pe_v[1]), .start(start_b),
        .out(out_b), .out_valid(valid_b), .slot(slot_b), .busy(busy_b), .frame_done(done_b));

    select_scan_n #(.NUM_CH(5), .CH_W(4), .EDGE_MODE(1)) dut_c (
        .clk_in(clk), .reset(rst_n), .in(in_c), .time_tick(tick), .en(en_v[2]),
        .cont(cont_v[2]), .ch_mask(mask_c), .parity_en(pe_v[2]), .start(start_c),
        .out(out_c), .out_valid(valid_c), .slot(slot_c), .busy(busy_c), .frame_done(done_c));

    // Observation word: {busy, start, out_valid, frame_done, slot[4:0], out[3:0]}
    function automatic logic [12:0] mk(input logic b, input logic s, input logic v,
                                       input logic d, input int sl, input int o);
        return {b, s, v, d, 5'(sl), 4'(o)};
    endfunction

    function automatic logic [12:0] get_obs(input int sel);
        case (sel)
            0:       return {busy_a, start_a, valid_a, done_a, slot_a, 3'b000, out_a};
            1:       return {busy_b, start_b, valid_b, done_b, slot_b, 3'b000, out_b};
            default: return {busy_c, start_c, valid_c, done_c, 2'b00, slot_c, out_c};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic set_in(input int sel, input logic [63:0] din, input logic [15:0] m,
                          input logic pe, input logic c);
        case (sel)
            0:       begin in_a = din[15:0]; mask_a = m;      end
            1:       begin in_b = din[15:0]; mask_b = m;      end
            default: begin in_c = din[19:0]; mask_c = m[4:0]; end
        endcase
        pe_v[sel]   = pe;
        cont_v[sel] = c;
    endtask

    // One step: output must hold after the first clk edge and change on the second
    task automatic do_step(input int sel, input logic [12:0] prev);
        if (sel == 1 && tick) begin
            @(negedge clk) tick = 1'b0;
            repeat (3) @(negedge clk);
            chk("fall_no_step", get_obs(sel), prev);
        end
        @(negedge clk) tick = ~tick;
        @(negedge clk);
        chk("one_edge_hold", get_obs(sel), prev);
        @(negedge clk);
    endtask

    task automatic run_frame(input int sel, input logic [63:0] din, input logic [15:0] m,
                             input logic pe, input logic c, input int act_idx, input int act);
        int n, w, word, stop;
        logic [3:0] par;
        n = (sel == 2) ? 5 : 16;
        w = (sel == 2) ? 4 : 1;
        par = '0;
        exp_q.delete();
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0));
        for (int k = 0; k < n; k++) begin
            if (m[k]) begin
                word = 32'((din >> (k * w)) & ((64'd1 << w) - 64'd1));
                par  = par ^ 4'(word);
                exp_q.push_back(mk(1, 0, 1, 0, k + 1, word));
            end
        end
        if (pe) exp_q.push_back(mk(1, 0, 1, 0, n + 1, int'(par)));
        exp_q.push_back(mk(1, 0, 0, 1, 0, 0));
        stop = act_idx;

        @(negedge clk);
        set_in(sel, din, m, pe, c);
        en_v[sel] = 1'b1;
        for (int f = 0; f < 2; f++) begin
            if (f == 0) @(negedge clk);
            chk("start_slot", get_obs(sel), exp_q[0]);
            if (!c || f == 1) en_v[sel] = 1'b0;
            for (int i = 1; i < exp_q.size(); i++) begin
                do_step(sel, exp_q[i-1]);
                chk("slot_step", get_obs(sel), exp_q[i]);
                if (i == stop) begin
                    stop = -1;
                    if (act == ACT_DROP) begin
                        en_v[sel] = 1'b0;
                        set_in(sel, ~din, ~m, ~pe, c);
                    end else if (act == ACT_RESET) begin
                        #2 rst_n = 1'b0;
                        tick = 1'b0;
                        #1 chk("async_reset", get_obs(sel), '0);
                        @(negedge clk);
                        chk("held_reset", get_obs(sel), '0);
                        rst_n = 1'b1;
                        @(negedge clk);
                        chk("restart_start", get_obs(sel), exp_q[0]);
                        en_v[sel] = 1'b0;
                        i = 0;
                    end
                end
            end
            @(negedge clk);
            if (!(en_v[sel] && c)) begin
                chk("idle_after", get_obs(sel), '0);
                break;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_a", get_obs(0), '0);
        chk("reset_b", get_obs(1), '0);
        chk("reset_c", get_obs(2), '0);
        rst_n = 1'b1;

        run_frame(0, 64'hA5C3, 16'hFFFF, 1'b0, 1'b0, -1, ACT_NONE);
        run_frame(0, 64'h0011, 16'h0011, 1'b1, 1'b0, -1, ACT_NONE);
        run_frame(0, 64'($urandom), 16'h0000, 1'b1, 1'b0, -1, ACT_NONE);
        run_frame(0, 64'($urandom), 16'h0000, 1'b0, 1'b0, -1, ACT_NONE);
        run_frame(0, 64'($urandom), 16'hFFFF, 1'b0, 1'b1, 9, ACT_DROP);
        run_frame(0, 64'($urandom), 16'($urandom), 1'b1, 1'b1, -1, ACT_NONE);
        run_frame(0, 64'($urandom), 16'hFFFF, 1'b0, 1'b1, 7, ACT_RESET);

        for (int r = 0; r < 3; r++)
            run_frame(1, 64'($urandom), 16'($urandom), 1'($urandom), 1'b0, -1, ACT_NONE);

        run_frame(2, 64'h9_4_C_3_5, 16'h001F, 1'b1, 1'b0, -1, ACT_NONE);
        for (int r = 0; r < 3; r++)
            run_frame(2, 64'($urandom), 16'($urandom), 1'($urandom), 1'b0, -1, ACT_NONE);
        run_frame(2, 64'($urandom), 16'h001F, 1'b1, 1'b1, 3, ACT_RESET);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
